grid_io_cfg_param: RTL and testbench
====================================

Name: grid_io_cfg_param

Overview:
- Parametrised successor of the fixed 8-pad left-edge IO grid tile.
- NUM_IO configurable pad slices, each with per-pad mode bits: direction, input synchroniser, output register, polarity invert.
- Configuration shifts through a gated ccff chain. A bit counter guards it, and the result commits atomically into a shadow (active) register.
- Sits on any fabric edge between the GPIO pads and the routing-facing inpad/outpad pins.

Parameters:
NUM_IO, 8, number of pad slices (>=1)
SYNC_STAGES, 2, input synchroniser depth when in_reg=1 (>=1)
CFG_PER_IO, 4, config bits per slice; fixed at 4, not overridable

Ports:
prog_clk  input  1  single clock for chain, shadow, and IO registers
pReset  input  1  reset, asynchronous and active-low
ccff_head  input  1  serial config in
ccff_en  input  1  shift enable for chain
ccff_load  input  1  commit chain to active config (single-cycle pulse)
ccff_tail  output  1  serial config out
cfg_full  output  1  exactly NUM_IO*4 bits shifted since last commit/reset
cfg_err  output  1  one-cycle pulse on a rejected load
outpad  input  NUM_IO  fabric-to-pad data, bit i = slice i
inpad  output  NUM_IO  pad-to-fabric data, bit i = slice i
gfpga_pad_GPIO_PAD  inout  NUM_IO  pads, bit i = slice i

Behaviour:
- Reset: pReset=0 asynchronously clears chain, active config, counter, sync flops, and out flops.
  - cfg_err=0, ccff_tail=0, cfg_full=0, inpad=0, all pads Z.
  - Reset mid-shift or mid-operation discards partial config; pads release to Z immediately, with no clock edge needed.
- Chain: shift register chain[NUM_IO*4-1:0], one bit per edge, only while ccff_en=1.
  - chain[0]<=ccff_head; chain[k]<=chain[k-1]; ccff_tail=chain[NUM_IO*4-1].
  - ccff_en=0 holds the chain.
- Slice i field = chain[4i+3:4i]:
  - bit0 oe (1 = output).
  - bit1 in_reg.
  - bit2 out_reg.
  - bit3 inv.
- Bit counter:
  - Increments per shift, saturating at NUM_IO*4.
  - cfg_full = (count==NUM_IO*4), registered from the counter.
  - Overshifting keeps cfg_full=1; the chain holds the last NUM_IO*4 bits.
- Commit, on an edge with ccff_load=1:
  - Accepted when ccff_en=0 and cfg_full=1. Active config <= chain and counter <= 0; the chain keeps its contents.
  - Otherwise rejected (cfg_full=0, or ccff_en=1 in the same cycle). Active config is unchanged, cfg_err=1 for the next cycle, and shifting proceeds normally if ccff_en=1.
- New active config affects pads starting with the cycle after the commit edge.
- Output path, per slice:
  - out_q <= outpad[i] every edge.
  - drv = (out_reg ? out_q : outpad[i]) ^ inv.
  - Pad = drv when oe=1, else Z.
  - Latency: 0 cycles combinational, 1 cycle registered.
- Input path, per slice:
  - s = pad ^ inv.
  - SYNC_STAGES-deep flop chain samples s every edge.
  - inpad[i] = oe ? 0 : (in_reg ? sync_last : s).
  - Latency: 0 cycles, or SYNC_STAGES cycles.
  - X/Z on an undriven pad propagates as-is; no keeper.
- Sync and out flops run continuously regardless of mode, so a mode switch shows pipeline contents, not reset values.

Test Plan:
- Reset: NUM_IO=8, pReset=0 → all pads Z, inpad=8'h00, ccff_tail=0, cfg_full=0. Release, hold 10 cycles idle → unchanged.
- Full config, all outputs: shift 32 bits giving every slice field 4'b0001, pulse ccff_load.
  - Expect cfg_full=1 before the load, 0 after; no cfg_err.
  - outpad=8'hA5 → pads read 8'hA5 combinationally.
  - Shifting 32 more bits → first-shifted bit appears on ccff_tail after 32 shifts.
- Registered and inverted output: slice 3 field 4'b1101 → pad3 = ~outpad[3] one cycle after outpad[3] toggles. Other slices (field 0) stay Z.
- Synchronised input, default SYNC_STAGES=2: slice 0 field 4'b0010; drive pad0 0→1 → inpad[0] rises exactly 2 edges later. With field 4'b0000, inpad[0] follows the pad in 0 cycles.
- Rejected loads:
  - ccff_load after 31 shifts → cfg_err pulse, pads unchanged.
  - ccff_load with ccff_en=1 and cfg_full=1 → cfg_err pulse, active config unchanged.
- Async reset mid-run: after a full config driving 8'hFF, assert pReset between edges → pads Z immediately. After release, cfg_full=0 and ccff_load gives cfg_err.

Source files
------------

// File: rtl/grid_io_cfg_param_if.sv
// ============================================================================
// Module      : grid_io_cfg_param_if
// Description : Configuration-chain bundle for the parametrised IO grid tile:
//               serial head/tail, shift enable, commit strobe and status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grid_io_cfg_param_if;
    logic ccff_head;
    logic ccff_en;
    logic ccff_load;
    logic ccff_tail;
    logic cfg_full;
    logic cfg_err;

    // Driver of the configuration stream (programmer / testbench)
    modport master (
        output ccff_head,
        output ccff_en,
        output ccff_load,
        input  ccff_tail,
        input  cfg_full,
        input  cfg_err
    );

    // The IO tile itself
    modport slave (
        input  ccff_head,
        input  ccff_en,
        input  ccff_load,
        output ccff_tail,
        output cfg_full,
        output cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/grid_io_cfg_param.sv
// ============================================================================
// Module      : grid_io_cfg_param
// Description : Parametrised IO grid tile. NUM_IO pad slices, each configured
//               by a 4-bit field {inv, out_reg, in_reg, oe} shifted through a
//               gated chain and committed atomically into an active register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_io_cfg_param #(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire                    prog_clk,
    input  wire                    pReset,
    grid_io_cfg_param_if.slave     cfg,
    input  wire   [NUM_IO-1:0]     outpad,
    output wire   [NUM_IO-1:0]     inpad,
    inout  wire   [NUM_IO-1:0]     gfpga_pad_GPIO_PAD
);

    // Field width is fixed by the slice decode below, so it is not a parameter.
    localparam int               CFG_PER_IO = 4;
    localparam int               CHAIN_W    = NUM_IO * CFG_PER_IO;
    localparam int               CNT_W      = $clog2(CHAIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CHAIN_W);

    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [CHAIN_W-1:0] active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               err_q, err_d;
    logic               load_ok;

    // Next-state for chain, counter, commit and error strobe
    always_comb begin
        chain_d  = chain_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        load_ok  = cfg.ccff_load & ~cfg.ccff_en & full_q;
        err_d    = cfg.ccff_load & ~load_ok;

        if (cfg.ccff_en) begin
            chain_d = {chain_q[CHAIN_W-2:0], cfg.ccff_head};
        end

        // load_ok excludes ccff_en, so commit and shift never coincide.
        if (load_ok) begin
            active_d = chain_q;
            cnt_d    = '0;
        end else if (cfg.ccff_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        full_d = (cnt_d == CNT_MAX);
    end

    // Configuration state registers
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            chain_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    assign cfg.ccff_tail = chain_q[CHAIN_W-1];
    assign cfg.cfg_full  = full_q;
    assign cfg.cfg_err   = err_q;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_slice
        logic                   oe;
        logic                   in_reg;
        logic                   out_reg;
        logic                   inv;
        logic                   out_q;
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic                   drv;
        logic                   s;

        assign oe      = active_q[CFG_PER_IO*i + 0];
        assign in_reg  = active_q[CFG_PER_IO*i + 1];
        assign out_reg = active_q[CFG_PER_IO*i + 2];
        assign inv     = active_q[CFG_PER_IO*i + 3];

        assign drv                   = (out_reg ? out_q : outpad[i]) ^ inv;
        assign gfpga_pad_GPIO_PAD[i] = oe ? drv : 1'bz;
        assign s                     = gfpga_pad_GPIO_PAD[i] ^ inv;

        if (SYNC_STAGES == 1) begin : g_sync1
            assign sync_d = s;
        end else begin : g_syncn
            assign sync_d = {sync_q[SYNC_STAGES-2:0], s};
        end

        // Output and synchroniser flops free-run whatever the slice mode
        always_ff @(posedge prog_clk or negedge pReset) begin
            if (!pReset) begin
                out_q  <= 1'b0;
                sync_q <= '0;
            end else begin
                out_q  <= outpad[i];
                sync_q <= sync_d;
            end
        end

        // Fabric sees 0 for output slices and while the tile is held in reset.
        assign inpad[i] = (!pReset || oe) ? 1'b0
                        : (in_reg ? sync_q[SYNC_STAGES-1] : s);
    end

endmodule

`default_nettype wire

// File: tb/tb_grid_io_cfg_param.sv
// ============================================================================
// Module      : tb_grid_io_cfg_param
// Description : Self-checking bench for grid_io_cfg_param (NUM_IO=8,
//               SYNC_STAGES=2) with a small expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_io_cfg_param;

    logic       prog_clk = 1'b0;
    logic       pReset   = 1'b0;
    logic [7:0] outpad   = 8'h00;
    logic [7:0] tb_oe    = 8'h00;
    logic [7:0] tb_drv   = 8'h00;
    wire  [7:0] inpad;
    wire  [7:0] gpio;
    wire  [7:0] pad_is_z;

    int checks   = 0;
    int failures = 0;

    logic sb[$];

    grid_io_cfg_param_if cfg_if ();

    grid_io_cfg_param #(
        .NUM_IO      (8),
        .SYNC_STAGES (2)
    ) dut (
        .prog_clk           (prog_clk),
        .pReset             (pReset),
        .cfg                (cfg_if),
        .outpad             (outpad),
        .inpad              (inpad),
        .gfpga_pad_GPIO_PAD (gpio)
    );

    for (genvar i = 0; i < 8; i++) begin : g_tb_pad
        assign gpio[i]     = tb_oe[i] ? tb_drv[i] : 1'bz;
        assign pad_is_z[i] = (gpio[i] === 1'bz);
    end

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Shift v[n-1] first down to v[0] last.
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            cfg_if.ccff_head = v[k];
            cfg_if.ccff_en   = 1'b1;
            tick();
        end
        cfg_if.ccff_en   = 1'b0;
        cfg_if.ccff_head = 1'b0;
    endtask

    task automatic pulse_load();
        cfg_if.ccff_load = 1'b1;
        tick();
        cfg_if.ccff_load = 1'b0;
    endtask

    task automatic test_reset();
        cfg_if.ccff_head = 1'b0;
        cfg_if.ccff_en   = 1'b0;
        cfg_if.ccff_load = 1'b0;
        pReset = 1'b0;
        #12;
        checks++; if (pad_is_z !== 8'hFF) begin failures++; $display("FAIL reset_pads_z: got %h want ff", pad_is_z); end
        checks++; if (inpad !== 8'h00) begin failures++; $display("FAIL reset_inpad: got %h want 00", inpad); end
        checks++; if (cfg_if.ccff_tail !== 1'b0) begin failures++; $display("FAIL reset_tail: got %b want 0", cfg_if.ccff_tail); end
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", cfg_if.cfg_full); end
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", cfg_if.cfg_err); end
        @(negedge prog_clk);
        pReset = 1'b1;
        tb_oe  = 8'hFF;
        tb_drv = 8'h00;
        repeat (10) tick();
        checks++; if (inpad !== 8'h00) begin failures++; $display("FAIL idle_inpad: got %h want 00", inpad); end
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL idle_full: got %b want 0", cfg_if.cfg_full); end
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL idle_err: got %b want 0", cfg_if.cfg_err); end
        checks++; if (cfg_if.ccff_tail !== 1'b0) begin failures++; $display("FAIL idle_tail: got %b want 0", cfg_if.ccff_tail); end
    endtask

    task automatic test_full_out();
        logic [31:0] model;
        logic [31:0] w;
        logic        exp;
        tb_oe = 8'h00;
        shift_bits(32'h11111111, 32);
        checks++; if (cfg_if.cfg_full !== 1'b1) begin failures++; $display("FAIL full_before_load: got %b want 1", cfg_if.cfg_full); end
        pulse_load();
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL good_load_err: got %b want 0", cfg_if.cfg_err); end
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL full_after_load: got %b want 0", cfg_if.cfg_full); end
        outpad = 8'hA5;
        #1;
        checks++; if (gpio !== 8'hA5) begin failures++; $display("FAIL comb_out: got %h want a5", gpio); end
        checks++; if (pad_is_z !== 8'h00) begin failures++; $display("FAIL comb_out_driven: z-mask %h want 00", pad_is_z); end

        model = 32'h11111111;
        w     = $urandom;
        for (int k = 31; k >= 0; k--) begin
            cfg_if.ccff_head = w[k];
            cfg_if.ccff_en   = 1'b1;
            model = {model[30:0], w[k]};
            sb.push_back(model[31]);
            tick();
            exp = sb.pop_front();
            checks++; if (cfg_if.ccff_tail !== exp) begin failures++; $display("FAIL tail_shift%0d: got %b want %b", 31 - k, cfg_if.ccff_tail, exp); end
        end
        cfg_if.ccff_en = 1'b0;
        checks++; if (cfg_if.ccff_tail !== w[31]) begin failures++; $display("FAIL tail_first_bit: got %b want %b", cfg_if.ccff_tail, w[31]); end
        checks++; if (cfg_if.cfg_full !== 1'b1) begin failures++; $display("FAIL full_after_reshift: got %b want 1", cfg_if.cfg_full); end
        checks++; if (gpio !== 8'hA5) begin failures++; $display("FAIL active_held: got %h want a5", gpio); end
    endtask

    task automatic test_reg_inv();
        logic exp;
        tb_oe  = 8'h00;
        outpad = 8'h00;
        shift_bits(32'h0000D000, 32);
        pulse_load();
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL reginv_load_err: got %b want 0", cfg_if.cfg_err); end
        tick();
        checks++; if (pad_is_z !== 8'hF7) begin failures++; $display("FAIL reginv_zmask: got %h want f7", pad_is_z); end
        checks++; if (gpio[3] !== 1'b1) begin failures++; $display("FAIL reginv_idle: got %b want 1", gpio[3]); end
        outpad[3] = 1'b1;
        #1;
        checks++; if (gpio[3] !== 1'b1) begin failures++; $display("FAIL reginv_not_comb: got %b want 1", gpio[3]); end
        sb.push_back(1'b0);
        tick();
        exp = sb.pop_front();
        checks++; if (gpio[3] !== exp) begin failures++; $display("FAIL reginv_rise: got %b want %b", gpio[3], exp); end
        outpad[3] = 1'b0;
        sb.push_back(1'b1);
        tick();
        exp = sb.pop_front();
        checks++; if (gpio[3] !== exp) begin failures++; $display("FAIL reginv_fall: got %b want %b", gpio[3], exp); end
        checks++; if (pad_is_z !== 8'hF7) begin failures++; $display("FAIL reginv_others_z: got %h want f7", pad_is_z); end
    endtask

    task automatic test_sync_in();
        logic exp;
        tb_oe  = 8'h01;
        tb_drv = 8'h00;
        shift_bits(32'h00000002, 32);
        pulse_load();
        tick();
        tick();
        checks++; if (inpad[0] !== 1'b0) begin failures++; $display("FAIL sync_idle: got %b want 0", inpad[0]); end
        tb_drv[0] = 1'b1;
        #1;
        checks++; if (inpad[0] !== 1'b0) begin failures++; $display("FAIL sync_edge0: got %b want 0", inpad[0]); end
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        sb.push_back(1'b1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            exp = sb.pop_front();
            checks++; if (inpad[0] !== exp) begin failures++; $display("FAIL sync_edge%0d: got %b want %b", e, inpad[0], exp); end
        end
        shift_bits(32'h00000000, 32);
        pulse_load();
        tb_drv[0] = 1'b0;
        #1;
        checks++; if (inpad[0] !== 1'b0) begin failures++; $display("FAIL direct_in_low: got %b want 0", inpad[0]); end
        tb_drv[0] = 1'b1;
        #1;
        checks++; if (inpad[0] !== 1'b1) begin failures++; $display("FAIL direct_in_high: got %b want 1", inpad[0]); end
    endtask

    task automatic test_reject();
        tb_oe = 8'h00;
        shift_bits(32'h11111111 >> 1, 31);
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL short_full: got %b want 0", cfg_if.cfg_full); end
        pulse_load();
        checks++; if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL short_load_err: got %b want 1", cfg_if.cfg_err); end
        checks++; if (pad_is_z !== 8'hFF) begin failures++; $display("FAIL short_load_pads: z-mask %h want ff", pad_is_z); end
        tick();
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b want 0", cfg_if.cfg_err); end
        shift_bits(32'h11111111, 1);
        checks++; if (cfg_if.cfg_full !== 1'b1) begin failures++; $display("FAIL completed_full: got %b want 1", cfg_if.cfg_full); end
        cfg_if.ccff_en   = 1'b1;
        cfg_if.ccff_load = 1'b1;
        tick();
        cfg_if.ccff_en   = 1'b0;
        cfg_if.ccff_load = 1'b0;
        checks++; if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL en_load_err: got %b want 1", cfg_if.cfg_err); end
        checks++; if (pad_is_z !== 8'hFF) begin failures++; $display("FAIL en_load_pads: z-mask %h want ff", pad_is_z); end
        checks++; if (cfg_if.cfg_full !== 1'b1) begin failures++; $display("FAIL en_load_full: got %b want 1", cfg_if.cfg_full); end
        tick();
        checks++; if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL en_load_err_clear: got %b want 0", cfg_if.cfg_err); end
    endtask

    task automatic test_async_reset();
        tb_oe = 8'h00;
        shift_bits(32'h11111111, 32);
        pulse_load();
        outpad = 8'hFF;
        #1;
        checks++; if (gpio !== 8'hFF) begin failures++; $display("FAIL pre_reset_drive: got %h want ff", gpio); end
        #1;
        pReset = 1'b0;
        #1;
        checks++; if (pad_is_z !== 8'hFF) begin failures++; $display("FAIL async_pads_z: z-mask %h want ff", pad_is_z); end
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL async_full: got %b want 0", cfg_if.cfg_full); end
        checks++; if (inpad !== 8'h00) begin failures++; $display("FAIL async_inpad: got %h want 00", inpad); end
        @(negedge prog_clk);
        pReset = 1'b1;
        tick();
        checks++; if (cfg_if.cfg_full !== 1'b0) begin failures++; $display("FAIL post_reset_full: got %b want 0", cfg_if.cfg_full); end
        pulse_load();
        checks++; if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL post_reset_load_err: got %b want 1", cfg_if.cfg_err); end
        checks++; if (pad_is_z !== 8'hFF) begin failures++; $display("FAIL post_reset_pads: z-mask %h want ff", pad_is_z); end
    endtask

    initial begin
        test_reset();
        test_full_out();
        test_reg_inv();
        test_sync_in();
        test_reject();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
